// File: rtl/sound_synth_multi_if.sv
// Register-write and audio-output bundle for sound_synth_multi.
// Handshake: wr_en is a one-cycle write strobe with no ready/back-pressure;
// the write is accepted on every rising clk edge where wr_en is high, one
// write per cycle. Outputs are free-running registered values.
interface sound_synth_multi_if #(
  parameter int NUM_CH = 4,
  parameter int FREQ_W = 12,
  parameter int VOL_W  = 4
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = VOL_W + $clog2(NUM_CH);

  logic              wr_en;
  logic [CH_W:0]     wr_addr;
  logic [FREQ_W-1:0] wr_data;
  logic [NUM_CH-1:0] tone_out;
  logic [SUM_W-1:0]  mix_out;
  logic              signal_out;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  tone_out, mix_out, signal_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output tone_out, mix_out, signal_out
  );
endinterface

// File: rtl/sound_synth_multi.sv
// Multi-channel square-wave sound generator: NUM_CH tone channels with
// programmable half-period and volume, a registered weighted-sum mixer and a
// first-order sigma-delta modulator producing a 1-bit audio stream.
// Optional feature macro: SOUND_SYNTH_NOISE_EN turns channel NUM_CH-1 into an
// LFSR noise channel (x^16+x^14+x^13+x^11+1, seed 16'hACE1).
// wr_addr = {channel, sel}; sel=0 writes the half-period, sel=1 the volume.
module sound_synth_multi #(
  parameter int NUM_CH = 4,
  parameter int FREQ_W = 12,
  parameter int VOL_W  = 4,
  parameter int DIV    = 256
) (
  input  logic               clk,
  input  logic               reset,
  sound_synth_multi_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = VOL_W + $clog2(NUM_CH);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  // Prescaler
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  // Per-channel registers
  logic [NUM_CH-1:0][FREQ_W-1:0] period_q, period_d;
  logic [NUM_CH-1:0][VOL_W-1:0]  vol_q, vol_d;
  logic [NUM_CH-1:0][FREQ_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]             tone_q, tone_d;

  // Mixer and sigma-delta
  logic [SUM_W-1:0] mix_q, mix_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             sig_q, sig_d;
  logic [SUM_W:0]   sd_sum;

  // Write address split
  logic [CH_W-1:0] wr_ch;
  logic            wr_sel;

`ifdef SOUND_SYNTH_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;
`endif

  assign wr_ch  = bus.wr_addr[CH_W:1];
  assign wr_sel = bus.wr_addr[0];

  // Tick prescaler: count 0..DIV-1, tick on the last count then wrap.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Register file writes; channel numbers >= NUM_CH match no slot and are dropped.
  always_comb begin
    period_d = period_q;
    vol_d    = vol_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.wr_en && (int'(wr_ch) == c)) begin
        if (wr_sel) vol_d[c]    = bus.wr_data[VOL_W-1:0];
        else        period_d[c] = bus.wr_data;
      end
    end
  end

`ifdef SOUND_SYNTH_NOISE_EN
  // Fibonacci feedback taps for x^16+x^14+x^13+x^11+1.
  always_comb begin
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  end
`endif

  // Channel counters: reload and toggle on a zero count, idle while period is 0.
  // The registered period is used, so a write only takes effect at the next reload.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (period_q[c] == '0) begin
          cnt_d[c]  = '0;
          tone_d[c] = 1'b0;
        end else if (cnt_q[c] == '0) begin
          cnt_d[c]  = period_q[c] - 1'b1;
          tone_d[c] = ~tone_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] - 1'b1;
        end
      end
    end
`ifdef SOUND_SYNTH_NOISE_EN
    // The last channel shifts its LFSR on reload instead of toggling.
    lfsr_d = lfsr_q;
    if (tick && (period_q[NUM_CH-1] != '0) && (cnt_q[NUM_CH-1] == '0)) begin
      lfsr_d             = {lfsr_fb, lfsr_q[15:1]};
      tone_d[NUM_CH-1]   = lfsr_d[0];
    end
`endif
  end

  // Weighted sum of active channels; cannot overflow SUM_W by construction.
  always_comb begin
    mix_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tone_q[c]) mix_d = mix_d + SUM_W'(vol_q[c]);
    end
  end

  // First-order sigma-delta: the accumulator carry is the output bit.
  always_comb begin
    sd_sum = {1'b0, acc_q} + {1'b0, mix_q};
    acc_d  = sd_sum[SUM_W-1:0];
    sig_d  = sd_sum[SUM_W];
  end

  // State registers; reset takes priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q    <= '0;
      period_q <= '0;
      vol_q    <= '0;
      cnt_q    <= '0;
      tone_q   <= '0;
      mix_q    <= '0;
      acc_q    <= '0;
      sig_q    <= 1'b0;
`ifdef SOUND_SYNTH_NOISE_EN
      lfsr_q   <= 16'hACE1;
`endif
    end else begin
      pre_q    <= pre_d;
      period_q <= period_d;
      vol_q    <= vol_d;
      cnt_q    <= cnt_d;
      tone_q   <= tone_d;
      mix_q    <= mix_d;
      acc_q    <= acc_d;
      sig_q    <= sig_d;
`ifdef SOUND_SYNTH_NOISE_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign bus.tone_out   = tone_q;
  assign bus.mix_out    = mix_q;
  assign bus.signal_out = sig_q;
endmodule

// File: tb/tb_sound_synth_multi.sv
// Testbench for sound_synth_multi. Three instances:
//   a: NUM_CH=4, DIV=1   (tone, mixer, sigma-delta, period change)
//   b: NUM_CH=3, DIV=1   (out-of-range channel, noise channel when enabled)
//   c: NUM_CH=1, DIV=3   (prescaler)
// Expected values come from closed-form timing derived from the behaviour
// description and are queued in exp_q before the DUT is observed.
`timescale 1ns/1ps
module tb_sound_synth_multi;
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  // Clock and reset-relative cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  sound_synth_multi_if #(.NUM_CH(4), .FREQ_W(12), .VOL_W(4)) a_if ();
  sound_synth_multi_if #(.NUM_CH(3), .FREQ_W(12), .VOL_W(4)) b_if ();
  sound_synth_multi_if #(.NUM_CH(1), .FREQ_W(12), .VOL_W(4)) c_if ();

  sound_synth_multi #(.NUM_CH(4), .FREQ_W(12), .VOL_W(4), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  sound_synth_multi #(.NUM_CH(3), .FREQ_W(12), .VOL_W(4), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));
  sound_synth_multi #(.NUM_CH(1), .FREQ_W(12), .VOL_W(4), .DIV(3)) dut_c (
    .clk(clk), .reset(reset), .bus(c_if.slave));

  // Driver: one write, returns at the negedge after the write edge with the
  // cycle index of that edge.
  task automatic wr(input int d, input int ch, input int sel, input int data,
                    output int unsigned edge_cyc);
    @(negedge clk);
    case (d)
      0: begin a_if.wr_en = 1'b1; a_if.wr_addr = 3'(ch * 2 + sel); a_if.wr_data = 12'(data); end
      1: begin b_if.wr_en = 1'b1; b_if.wr_addr = 3'(ch * 2 + sel); b_if.wr_data = 12'(data); end
      default: begin c_if.wr_en = 1'b1; c_if.wr_addr = 2'(ch * 2 + sel); c_if.wr_data = 12'(data); end
    endcase
    @(negedge clk);
    a_if.wr_en = 1'b0;
    b_if.wr_en = 1'b0;
    c_if.wr_en = 1'b0;
    edge_cyc = cyc;
  endtask

  // Expected tone of the DIV=3, period=2 channel after edge k, period written at edge w.
  function automatic int c_tone(int unsigned k, int unsigned w);
    int m;
    m = int'(k / 3) - int'(w / 3);
    if (m <= 0) return 0;
    return (((m - 1) / 2) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1;
    a_if.wr_en = 1'b1; a_if.wr_addr = 3'b000; a_if.wr_data = 12'd1;
    b_if.wr_en = 1'b1; b_if.wr_addr = 3'b000; b_if.wr_data = 12'd1;
    c_if.wr_en = 1'b1; c_if.wr_addr = 2'b00;  c_if.wr_data = 12'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {5'd0, a_if.signal_out, a_if.tone_out, a_if.mix_out};
    checks++;
    if (got !== 16'd0) begin
      errors++; $display("FAIL reset_a_outputs got=%h exp=0000", got);
    end
    got = {6'd0, b_if.signal_out, b_if.tone_out, b_if.mix_out};
    checks++;
    if (got !== 16'd0) begin
      errors++; $display("FAIL reset_b_outputs got=%h exp=0000", got);
    end
    got = {10'd0, c_if.signal_out, c_if.tone_out, c_if.mix_out};
    checks++;
    if (got !== 16'd0) begin
      errors++; $display("FAIL reset_c_outputs got=%h exp=0000", got);
    end
    reset = 1'b0;
    a_if.wr_en = 1'b0; b_if.wr_en = 1'b0; c_if.wr_en = 1'b0;
    repeat (8) @(negedge clk);
    got = {6'd0, a_if.tone_out, b_if.tone_out, c_if.tone_out, a_if.signal_out, b_if.signal_out};
    checks++;
    if (got !== 16'd0) begin
      errors++; $display("FAIL reset_no_write got=%h exp=0000", got);
    end
  endtask

  task automatic test_single_tone();
    int unsigned e;
    int t, tp;
    logic [15:0] got, exp_v;
    wr(0, 0, 1, 15, e);
    wr(0, 0, 0, 5, e);
    for (int n = 1; n <= 30; n++) begin
      t  = (((n - 1) / 5) % 2 == 0) ? 1 : 0;
      tp = (n == 1) ? 0 : ((((n - 2) / 5) % 2 == 0) ? 1 : 0);
      exp_q.push_back(16'((t << 6) | (15 * tp)));
    end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      got   = {6'd0, a_if.tone_out, a_if.mix_out};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL single_tone n=%0d got=%h exp=%h", n, got, exp_v);
      end
    end
    wr(0, 0, 0, 0, e);
    @(negedge clk);
    checks++;
    if (a_if.tone_out !== 4'b0000) begin
      errors++; $display("FAIL single_tone_silence got=%b exp=0000", a_if.tone_out);
    end
  endtask

  task automatic test_sigma_delta();
    int unsigned e;
    bit sd[200];
    int ones;
    int starts[3] = '{0, 37, 136};
    logic [15:0] got, exp_v;
    wr(0, 0, 1, 15, e);
    wr(0, 0, 0, 4095, e);
    repeat (4) @(negedge clk);
    got = {6'd0, a_if.tone_out, a_if.mix_out};
    checks++;
    if (got !== 16'h004F) begin
      errors++; $display("FAIL sd_steady_mix got=%h exp=004f", got);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      sd[i] = a_if.signal_out;
    end
    for (int w = 0; w < 3; w++) exp_q.push_back(16'd15);
    for (int w = 0; w < 3; w++) begin
      ones = 0;
      for (int j = 0; j < 64; j++) ones += int'(sd[starts[w] + j]);
      exp_v = exp_q.pop_front();
      checks++;
      if (16'(ones) !== exp_v) begin
        errors++; $display("FAIL sd_density15 start=%0d got=%0d exp=%0d", starts[w], ones, exp_v);
      end
    end
    // Volume change reaches the mixer one cycle after the write.
    exp_q.push_back(16'd15);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd5);
    wr(0, 0, 1, 5, e);
    exp_v = exp_q.pop_front();
    checks++;
    if ({10'd0, a_if.mix_out} !== exp_v) begin
      errors++; $display("FAIL vol_write_same_cycle got=%0d exp=%0d", a_if.mix_out, exp_v);
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if ({10'd0, a_if.mix_out} !== exp_v) begin
      errors++; $display("FAIL vol_write_next_cycle got=%0d exp=%0d", a_if.mix_out, exp_v);
    end
    ones = 0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      ones += int'(a_if.signal_out);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (16'(ones) !== exp_v) begin
      errors++; $display("FAIL sd_density5 got=%0d exp=%0d", ones, exp_v);
    end
    wr(0, 0, 0, 0, e);
    repeat (3) @(negedge clk);
    got = {5'd0, a_if.signal_out, a_if.tone_out, a_if.mix_out};
    checks++;
    if (got !== 16'd0) begin
      errors++; $display("FAIL sd_silence got=%h exp=0000", got);
    end
  endtask

  task automatic test_full_scale();
    int unsigned e;
    int ones;
    logic [15:0] got, exp_v;
    for (int c = 0; c < 4; c++) wr(0, c, 1, 15, e);
    for (int c = 0; c < 4; c++) wr(0, c, 0, 1, e);
    @(negedge clk);
    // Channels written two edges apart all toggle on odd edges after the first write.
    for (int n = 8; n <= 40; n++)
      exp_q.push_back(16'((((n % 2) == 1) ? (15 << 6) : 0) | (((n % 2) == 0) ? 60 : 0)));
    for (int n = 8; n <= 40; n++) begin
      @(negedge clk);
      got   = {6'd0, a_if.tone_out, a_if.mix_out};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL full_scale_alt n=%0d got=%h exp=%h", n, got, exp_v);
      end
    end
    ones = 0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      ones += int'(a_if.signal_out);
    end
    checks++;
    if (ones != 30) begin
      errors++; $display("FAIL full_scale_alt_density got=%0d exp=30", ones);
    end
    for (int c = 0; c < 4; c++) wr(0, c, 0, 0, e);
    for (int c = 0; c < 4; c++) wr(0, c, 0, 4095, e);
    repeat (4) @(negedge clk);
    got = {6'd0, a_if.tone_out, a_if.mix_out};
    checks++;
    if (got !== 16'h03FC) begin
      errors++; $display("FAIL full_scale_mix60 got=%h exp=03fc", got);
    end
    ones = 0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      ones += int'(a_if.signal_out);
    end
    checks++;
    if (ones != 60) begin
      errors++; $display("FAIL full_scale_density60 got=%0d exp=60", ones);
    end
    for (int c = 0; c < 4; c++) wr(0, c, 0, 0, e);
    for (int c = 0; c < 4; c++) wr(0, c, 1, 0, e);
    repeat (2) @(negedge clk);
    checks++;
    if (a_if.tone_out !== 4'b0000) begin
      errors++; $display("FAIL full_scale_silence got=%b exp=0000", a_if.tone_out);
    end
  endtask

  task automatic test_period_change();
    int unsigned e, e2;
    int t, tp;
    logic [15:0] got, exp_v;
    wr(0, 1, 1, 7, e);
    wr(0, 1, 0, 10, e);
    repeat (2) @(negedge clk);
    wr(0, 1, 0, 3, e2);
    checks++;
    if (e2 - e != 4) begin
      errors++; $display("FAIL period_change_timing got=%0d exp=4", e2 - e);
    end
    // First half-period is the full 10 ticks, then 3-tick half-periods.
    for (int n = 5; n <= 20; n++) begin
      t  = (n <= 10) ? 1 : ((((n - 11) / 3) % 2 == 0) ? 0 : 1);
      tp = ((n - 1) <= 10) ? 1 : ((((n - 12) / 3) % 2 == 0) ? 0 : 1);
      exp_q.push_back(16'((t << 7) | (7 * tp)));
    end
    for (int n = 5; n <= 20; n++) begin
      @(negedge clk);
      got   = {6'd0, a_if.tone_out, a_if.mix_out};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL period_change n=%0d got=%h exp=%h", n, got, exp_v);
      end
    end
    // Period 0 written at edge 22: that tick still counts, the next one idles.
    exp_q.push_back(16'((1 << 7) | 7));
    exp_q.push_back(16'd7);
    for (int n = 24; n <= 26; n++) exp_q.push_back(16'd0);
    wr(0, 1, 0, 0, e2);
    for (int n = 22; n <= 26; n++) begin
      if (n > 22) @(negedge clk);
      got   = {6'd0, a_if.tone_out, a_if.mix_out};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL period_zero n=%0d got=%h exp=%h", n, got, exp_v);
      end
    end
  endtask

  task automatic test_invalid_addr();
    int unsigned e;
    int tv[21];
    logic [15:0] got, exp_v;
`ifdef SOUND_SYNTH_NOISE_EN
    logic [15:0] l;
`endif
    wr(1, 3, 0, 1, e);
    wr(1, 3, 1, 15, e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got = {6'd0, b_if.signal_out, b_if.tone_out, b_if.mix_out};
      checks++;
      if (got !== 16'd0) begin
        errors++; $display("FAIL invalid_addr i=%0d got=%h exp=0000", i, got);
      end
    end
    wr(1, 2, 1, 9, e);
`ifdef SOUND_SYNTH_NOISE_EN
    wr(1, 2, 0, 1, e);
    l = 16'hACE1;
    tv[0] = 0;
    for (int n = 1; n <= 20; n++) begin
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      tv[n] = int'(l[0]);
    end
`else
    wr(1, 2, 0, 2, e);
    tv[0] = 0;
    for (int n = 1; n <= 20; n++) tv[n] = (((n - 1) / 2) % 2 == 0) ? 1 : 0;
`endif
    for (int n = 1; n <= 20; n++) exp_q.push_back(16'((tv[n] << 8) | (9 * tv[n - 1])));
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      got   = {7'd0, b_if.tone_out, b_if.mix_out};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL valid_ch2 n=%0d got=%h exp=%h", n, got, exp_v);
      end
    end
  endtask

  task automatic test_prescaler();
    int unsigned e, w;
    logic [15:0] got, exp_v;
    wr(2, 0, 1, 9, e);
    wr(2, 0, 0, 2, w);
    for (int i = 1; i <= 40; i++)
      exp_q.push_back(16'((c_tone(w + i, w) << 4) | (9 * c_tone(w + i - 1, w))));
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      got   = {11'd0, c_if.tone_out, c_if.mix_out};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL prescaler i=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_sigma_delta();
`ifndef SOUND_SYNTH_NOISE_EN
    test_full_scale();
`endif
    test_period_change();
    test_invalid_addr();
`ifndef SOUND_SYNTH_NOISE_EN
    test_prescaler();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
